// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   clog2     : constant ceil(log2(v)) helper
//   cnt_width : digit counter width, never less than one bit
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// DIGIT-bit ripple chain of full-adder cells (purely combinational).
//   x, y     : digit operands
//   cin      : carry into bit 0
//   s        : digit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit digit per clock, LSB first,
// carry registered between digits. WIDTH/DIGIT cycles per operation.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request an operation (sampled only when not busy)
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a, b       : operands (sampled with start)
//   busy       : operation in progress
//   done       : one-cycle pulse, result/co/ovf updated in this cycle
//   result     : sum/difference modulo 2^WIDTH
//   co         : carry out of the MSB (for sub, 1 = no borrow)
//   ovf        : two's-complement overflow
//
// Handshake: start is a level sampled on a rising edge while the block is
// in IDLE or DONE; busy rises the following cycle and stays high for
// WIDTH/DIGIT cycles, then done pulses for exactly one cycle. result, co and
// ovf only change on that completion edge (or reset).
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: illegal WIDTH/DIGIT combination");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x        (op_a[DIGIT-1:0]),
    .y        (op_b[DIGIT-1:0]),
    .cin      (carry),
    .s        (dsum),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
  // Written as a shift of the concatenation so DIGIT == WIDTH needs no
  // special case (the accumulator is then simply replaced by dsum).
  assign acc_next = WIDTH'({dsum, acc} >> DIGIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for accepting start (back-to-back ops).
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;           // +1 completes the two's complement of b
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry <= dcout;
          acc   <= acc_next;
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          if (cnt == LAST) begin
            result <= acc_next;
            co     <= dcout;
            ovf    <= dcmsb ^ dcout;  // last digit's top bit is the word MSB
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed testbench for serial_add_sub: a 16/4 instance for the timing,
// handshake, reset and flag vectors, plus 4/1 and 4/4 instances driven
// exhaustively against a small arithmetic reference.
module tb_serial_add_sub;

  // clock / reset
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, WIDTH=16 DIGIT=4
  logic        start_m, sub_m, busy_m, done_m, co_m, ovf_m;
  logic [15:0] a_m, b_m, res_m;

  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_main (
    .clk(clk), .reset(reset), .start(start_m), .sub(sub_m), .a(a_m), .b(b_m),
    .busy(busy_m), .done(done_m), .result(res_m), .co(co_m), .ovf(ovf_m)
  );

  // WIDTH=4 DIGIT=1
  logic       start_p, sub_p, busy_p, done_p, co_p, ovf_p;
  logic [3:0] a_p, b_p, res_p;

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start_p), .sub(sub_p), .a(a_p), .b(b_p),
    .busy(busy_p), .done(done_p), .result(res_p), .co(co_p), .ovf(ovf_p)
  );

  // WIDTH=4 DIGIT=4
  logic       start_q, sub_q, busy_q, done_q, co_q, ovf_q;
  logic [3:0] a_q, b_q, res_q;

  serial_add_sub #(.WIDTH(4), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start_q), .sub(sub_q), .a(a_q), .b(b_q),
    .busy(busy_q), .done(done_q), .result(res_q), .co(co_q), .ovf(ovf_q)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard for the exhaustive runs: {co, ovf, result}
  logic [5:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one 16-bit op in the current cycle; returns in its done cycle.
  task automatic op16(input string tag, input logic s, input logic [15:0] x,
                      input logic [15:0] y, input logic [15:0] er,
                      input logic eco, input logic eov);
    a_m = x; b_m = y; sub_m = s; start_m = 1'b1;
    tick();
    start_m = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check({tag, " busy/done run"}, {30'b0, busy_m, done_m}, 32'h2);
      tick();
    end
    check({tag, " busy/done end"}, {30'b0, busy_m, done_m}, 32'h1);
    check({tag, " result"}, {16'b0, res_m}, {16'b0, er});
    check({tag, " co"},  {31'b0, co_m},  {31'b0, eco});
    check({tag, " ovf"}, {31'b0, ovf_m}, {31'b0, eov});
  endtask

  function automatic logic [5:0] ref4(input logic s, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] yy;
    logic [4:0] t;
    logic       v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {4'b0, s};
    v  = (x[3] == yy[3]) && (t[3] != x[3]);
    return {t[4], v, t[3:0]};
  endfunction

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         seen;
    logic [5:0] exp_v;

    reset = 1'b1;
    start_m = 0; sub_m = 0; a_m = '0; b_m = '0;
    start_p = 0; sub_p = 0; a_p = '0; b_p = '0;
    start_q = 0; sub_q = 0; a_q = '0; b_q = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst busy/done", {30'b0, busy_m, done_m}, 32'h0);
    check("rst result", {16'b0, res_m}, 32'h0);
    check("rst co/ovf", {30'b0, co_m, ovf_m}, 32'h0);
    check("rst small", {20'b0, res_p, res_q, co_p, ovf_p, co_q, ovf_q}, 32'h0);

    // basic add, then done must drop
    op16("add 1234+1111", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);
    tick();
    check("done one cycle", {31'b0, done_m}, 32'h0);

    // carry / overflow corners
    op16("add ffff+0001", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    tick();
    op16("add 7fff+0001", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    tick();
    op16("sub 0005-0007", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    tick();
    op16("sub 8000-0001", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    tick();

    // reset in cycle 2 of an operation
    a_m = 16'hAAAA; b_m = 16'h1111; sub_m = 1'b0; start_m = 1'b1;
    tick();                 // cycle 1
    start_m = 1'b0;
    tick();                 // cycle 2
    reset = 1'b1;
    tick();                 // cycle 3
    reset = 1'b0;
    check("midrun rst busy/done", {30'b0, busy_m, done_m}, 32'h0);
    check("midrun rst result", {16'b0, res_m}, 32'h0);
    check("midrun rst co/ovf", {30'b0, co_m, ovf_m}, 32'h0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (done_m) seen = 1'b1;
    end
    check("no done after rst", {31'b0, seen}, 32'h0);
    op16("after rst 0f0f+00f1", 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0);
    tick();

    // ignored start while busy, then back-to-back start in DONE
    a_m = 16'h1111; b_m = 16'h2222; sub_m = 1'b0; start_m = 1'b1;
    tick();                 // cycle 1
    start_m = 1'b0;
    tick();                 // cycle 2
    a_m = 16'hF000; b_m = 16'hF000; sub_m = 1'b1; start_m = 1'b1;
    tick();                 // cycle 3
    start_m = 1'b0;
    check("b2b busy c3", {31'b0, busy_m}, 32'h1);
    tick();                 // cycle 4
    tick();                 // cycle 5
    check("b2b first done", {31'b0, done_m}, 32'h1);
    check("b2b first result", {16'b0, res_m}, 32'h3333);
    a_m = 16'h0001; b_m = 16'h0002; sub_m = 1'b0; start_m = 1'b1;
    tick();                 // cycle 6
    start_m = 1'b0;
    check("b2b busy c6", {30'b0, busy_m, done_m}, 32'h2);
    tick(); tick(); tick(); // cycle 9
    check("b2b hold c9 done", {31'b0, done_m}, 32'h0);
    check("b2b hold c9 result", {16'b0, res_m}, 32'h3333);
    tick();                 // cycle 10
    check("b2b second done", {31'b0, done_m}, 32'h1);
    check("b2b second result", {16'b0, res_m}, 32'h0003);
    tick();
    check("b2b done drops", {31'b0, done_m}, 32'h0);

    // exhaustive WIDTH=4 DIGIT=1, back-to-back in DONE
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a_p = 4'(x); b_p = 4'(y); sub_p = s[0]; start_p = 1'b1;
          exp_q.push_back(ref4(s[0], 4'(x), 4'(y)));
          tick();
          start_p = 1'b0;
          lat = 1;
          while (!done_p && lat < 12) begin
            tick();
            lat++;
          end
          check("d1 latency", 32'(lat), 32'd5);
          exp_v = exp_q.pop_front();
          check("d1 co/ovf/result", {26'b0, co_p, ovf_p, res_p}, {26'b0, exp_v});
        end
      end
    end
    tick();

    // exhaustive WIDTH=4 DIGIT=4
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a_q = 4'(x); b_q = 4'(y); sub_q = s[0]; start_q = 1'b1;
          exp_q.push_back(ref4(s[0], 4'(x), 4'(y)));
          tick();
          start_q = 1'b0;
          lat = 1;
          while (!done_q && lat < 12) begin
            tick();
            lat++;
          end
          check("d4 latency", 32'(lat), 32'd2);
          exp_v = exp_q.pop_front();
          check("d4 co/ovf/result", {26'b0, co_q, ovf_q, res_q}, {26'b0, exp_v});
        end
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
